// File: rtl/matrix_stream_decoder.sv
// Oversampling decoder for the APA102-style LED-matrix serial stream.
// Turns the led_clk/led_data pair back into per-pixel records and frame status strobes.
module matrix_stream_decoder #(
    parameter int NUM_LEDS = 64,
    parameter int ZERO_RUN = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_clk,
    input  logic       led_data,
    output logic       pix_valid,
    output logic [5:0] pix_idx,
    output logic [4:0] pix_bright,
    output logic [7:0] pix_blue,
    output logic [7:0] pix_green,
    output logic [7:0] pix_red,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] frame_count,
    output logic       in_frame
);

    localparam int ZW = $clog2(ZERO_RUN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [5:0]    LAST_IDX  = 6'(NUM_LEDS - 1);
    localparam logic [ZW-1:0] ZERO_LAST = ZW'(ZERO_RUN - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        HUNT,
        ARMED,
        PIXEL
    } state_t;

    state_t        state, state_next;
    logic          clk_q, clk_q_d, dat_q;
    logic          rise;
    logic [ZW-1:0] zcnt, zcnt_next;
    logic [4:0]    bitcnt, bitcnt_next;
    logic [30:0]   shreg, shreg_next;
    logic [TW-1:0] idle, idle_next;
    logic [5:0]    cur_idx, cur_idx_next;
    logic [31:0]   word;
    logic          valid_next, done_next, err_next;

    // Clock and data are sampled once; clk_q starts high so a led_clk held high
    // across reset release is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_q   <= 1'b1;
            clk_q_d <= 1'b1;
            dat_q   <= 1'b0;
        end else begin
            clk_q   <= led_clk;
            clk_q_d <= clk_q;
            dat_q   <= led_data;
        end
    end

    assign rise     = clk_q & ~clk_q_d;
    assign word     = {shreg, dat_q};
    assign in_frame = (state == PIXEL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HUNT;
            zcnt    <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            idle    <= '0;
            cur_idx <= '0;
        end else begin
            state   <= state_next;
            zcnt    <= zcnt_next;
            bitcnt  <= bitcnt_next;
            shreg   <= shreg_next;
            idle    <= idle_next;
            cur_idx <= cur_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        zcnt_next    = zcnt;
        bitcnt_next  = bitcnt;
        shreg_next   = shreg;
        idle_next    = idle;
        cur_idx_next = cur_idx;
        valid_next   = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state)
            HUNT: begin
                if (rise) begin
                    if (dat_q) begin
                        zcnt_next = '0;
                    end else if (zcnt == ZERO_LAST) begin
                        zcnt_next  = '0;
                        state_next = ARMED;
                    end else begin
                        zcnt_next = zcnt + 1'b1;
                    end
                end
            end

            ARMED: begin
                if (rise && dat_q) begin
                    state_next  = PIXEL;
                    bitcnt_next = 5'd1;
                    shreg_next  = 31'd1;
                    idle_next   = '0;
                end
            end

            PIXEL: begin
                if (rise) begin
                    idle_next   = '0;
                    shreg_next  = word[30:0];
                    bitcnt_next = bitcnt + 1'b1;
                    if (bitcnt == 5'd31) begin
                        if (word[31:29] == 3'b111) begin
                            valid_next = 1'b1;
                            if (cur_idx == LAST_IDX) begin
                                done_next    = 1'b1;
                                cur_idx_next = '0;
                                zcnt_next    = '0;
                                state_next   = HUNT;
                            end else begin
                                cur_idx_next = cur_idx + 1'b1;
                            end
                        end else begin
                            err_next     = 1'b1;
                            cur_idx_next = '0;
                            zcnt_next    = '0;
                            state_next   = HUNT;
                        end
                    end
                end else if (idle == IDLE_LAST) begin
                    // A stalled driver abandons the frame; a rise this cycle would have won.
                    err_next     = 1'b1;
                    cur_idx_next = '0;
                    zcnt_next    = '0;
                    idle_next    = '0;
                    state_next   = HUNT;
                end else begin
                    idle_next = idle + 1'b1;
                end
            end

            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Pixel fields are only reloaded with a new record and otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_idx     <= '0;
            pix_bright  <= '0;
            pix_blue    <= '0;
            pix_green   <= '0;
            pix_red     <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            pix_valid  <= valid_next;
            frame_done <= done_next;
            frame_err  <= err_next;
            if (valid_next) begin
                pix_idx    <= cur_idx;
                pix_bright <= word[28:24];
                pix_blue   <= word[23:16];
                pix_green  <= word[15:8];
                pix_red    <= word[7:0];
            end
            if (done_next) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_decoder.sv
// Scoreboard bench for matrix_stream_decoder: a 64-LED instance for frame-level behaviour
// and a 1-LED, short-start-run instance for the frame_count wrap over 256 frames.
module tb_matrix_stream_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ledClk, ledData;
    logic       pixValid, frameDone, frameErr, inFrame;
    logic [5:0] pixIdx;
    logic [4:0] pixBright;
    logic [7:0] pixBlue, pixGreen, pixRed, frameCount;

    logic       sLedClk, sLedData;
    logic       sPixValid, sFrameDone, sFrameErr, sInFrame;
    logic [5:0] sPixIdx;
    logic [4:0] sPixBright;
    logic [7:0] sPixBlue, sPixGreen, sPixRed, sFrameCount;

    typedef struct packed {
        logic [5:0]  idx;
        logic [28:0] payload;
        logic        done;
        logic [7:0]  fc;
    } exp_t;

    exp_t sbQueue[$];
    int   checksDone = 0;
    int   checksPassed = 0;
    int   errCount = 0;
    int   sValidCount = 0;
    int   sErrCount = 0;
    int   expFc = 0;

    matrix_stream_decoder dut (
        .clk(clk), .reset(reset), .led_clk(ledClk), .led_data(ledData),
        .pix_valid(pixValid), .pix_idx(pixIdx), .pix_bright(pixBright),
        .pix_blue(pixBlue), .pix_green(pixGreen), .pix_red(pixRed),
        .frame_done(frameDone), .frame_err(frameErr),
        .frame_count(frameCount), .in_frame(inFrame)
    );

    matrix_stream_decoder #(.NUM_LEDS(1), .ZERO_RUN(8), .TIMEOUT(16)) dutSmall (
        .clk(clk), .reset(reset), .led_clk(sLedClk), .led_data(sLedData),
        .pix_valid(sPixValid), .pix_idx(sPixIdx), .pix_bright(sPixBright),
        .pix_blue(sPixBlue), .pix_green(sPixGreen), .pix_red(sPixRed),
        .frame_done(sFrameDone), .frame_err(sFrameErr),
        .frame_count(sFrameCount), .in_frame(sInFrame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checksDone++;
        if (obs === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit: led_clk low for lowCycles clk periods, then high for one.
    task automatic applyStimulus(input logic b, input int lowCycles, input bit toSmall);
        if (toSmall) begin
            sLedClk = 1'b0; sLedData = b;
        end else begin
            ledClk = 1'b0; ledData = b;
        end
        repeat (lowCycles) tick();
        if (toSmall) sLedClk = 1'b1;
        else ledClk = 1'b1;
        tick();
    endtask

    task automatic sendZeros(input int n, input bit toSmall);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1, toSmall);
    endtask

    task automatic sendWord(input logic [31:0] w, input bit toSmall);
        for (int i = 31; i >= 0; i--) applyStimulus(w[i], 1, toSmall);
    endtask

    task automatic expectWord(input logic [31:0] w, input int idx, input bit done);
        exp_t e;
        if (done) expFc = (expFc + 1) % 256;
        e.idx     = 6'(idx);
        e.payload = w[28:0];
        e.done    = done;
        e.fc      = 8'(expFc);
        sbQueue.push_back(e);
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] r;
        r = $urandom;
        return {3'b111, r[28:0]};
    endfunction

    // A complete decodable frame: start run, 64 good words, all pushed to the scoreboard.
    task automatic sendGoodFrame(input int zeros, input bit fixedWord);
        logic [31:0] w;
        sendZeros(zeros, 1'b0);
        for (int i = 0; i < 64; i++) begin
            w = fixedWord ? 32'hF0000F00 : randWord();
            expectWord(w, i, i == 63);
            sendWord(w, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frameErr) errCount++;
        if (sPixValid) sValidCount++;
        if (sFrameErr) sErrCount++;
        if (pixValid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_pix_valid", {58'd0, pixIdx}, 64'hFFFF);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("pix_idx", {58'd0, pixIdx}, {58'd0, e.idx});
                checkOutput("pix_fields", {35'd0, pixBright, pixBlue, pixGreen, pixRed},
                            {35'd0, e.payload});
                checkOutput("frame_done_flag", {63'd0, frameDone}, {63'd0, e.done});
                if (e.done) checkOutput("frame_count", {56'd0, frameCount}, {56'd0, e.fc});
            end
        end else if (frameDone) begin
            checkOutput("frame_done_without_pix", 64'd1, 64'd0);
        end
    end

    initial begin
        logic [31:0] w;
        ledClk = 1'b0; ledData = 1'b0; sLedClk = 1'b0; sLedData = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("reset_outputs",
                    {17'd0, pixValid, pixIdx, pixBright, pixBlue, pixGreen, pixRed,
                     frameDone, frameErr, frameCount, inFrame}, 64'd0);
        reset = 1'b0;
        tick();

        $display("[TB] T1 fixed-pattern frame");
        sendGoodFrame(32, 1'b1);
        sendZeros(64, 1'b0);
        checkOutput("t1_sb_empty", 64'(sbQueue.size()), 64'd0);
        checkOutput("t1_frame_count", {56'd0, frameCount}, 64'd1);
        checkOutput("t1_no_err", 64'(errCount), 64'd0);

        $display("[TB] T2 bad header at word 5");
        sendZeros(32, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w = randWord();
            expectWord(w, i, 1'b0);
            sendWord(w, 1'b0);
        end
        sendWord(32'h70070000, 1'b0);
        repeat (4) tick();
        checkOutput("t2_err_once", 64'(errCount), 64'd1);
        checkOutput("t2_in_frame", {63'd0, inFrame}, 64'd0);
        checkOutput("t2_sb_empty", 64'(sbQueue.size()), 64'd0);
        sendGoodFrame(32, 1'b0);
        sendZeros(8, 1'b0);
        checkOutput("t2_frame_count", {56'd0, frameCount}, 64'd2);

        $display("[TB] T3 stall of 20 then 15 idle cycles");
        sendZeros(32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            w = randWord();
            expectWord(w, i, 1'b0);
            sendWord(w, 1'b0);
        end
        w = randWord();
        for (int i = 31; i > 19; i--) applyStimulus(w[i], 1, 1'b0);
        checkOutput("t3_in_frame_before_stall", {63'd0, inFrame}, 64'd1);
        applyStimulus(w[19], 20, 1'b0);
        checkOutput("t3_timeout_err", 64'(errCount), 64'd2);
        checkOutput("t3_hunt", {63'd0, inFrame}, 64'd0);
        sendZeros(32, 1'b0);
        for (int i = 0; i < 64; i++) begin
            w = randWord();
            expectWord(w, i, i == 63);
            if (i == 10) begin
                for (int b = 31; b >= 0; b--) applyStimulus(w[b], (b == 19) ? 15 : 1, 1'b0);
            end else begin
                sendWord(w, 1'b0);
            end
        end
        repeat (4) tick();
        checkOutput("t3_no_err_15", 64'(errCount), 64'd2);
        checkOutput("t3_sb_empty", 64'(sbQueue.size()), 64'd0);

        $display("[TB] T4 31-zero then 33-zero start run");
        sendZeros(31, 1'b0);
        for (int i = 0; i < 64; i++) sendWord(randWord(), 1'b0);
        repeat (4) tick();
        checkOutput("t4_short_run_frame_count", {56'd0, frameCount}, 64'd3);
        sendGoodFrame(33, 1'b0);
        sendZeros(64, 1'b0);
        checkOutput("t4_frame_count", {56'd0, frameCount}, 64'd4);
        checkOutput("t4_no_err", 64'(errCount), 64'd2);

        $display("[TB] T5 reset during pixel 40");
        sendZeros(32, 1'b0);
        for (int i = 0; i < 40; i++) begin
            w = randWord();
            expectWord(w, i, 1'b0);
            sendWord(w, 1'b0);
        end
        w = randWord();
        for (int i = 31; i > 21; i--) applyStimulus(w[i], 1, 1'b0);
        checkOutput("t5_sb_empty", 64'(sbQueue.size()), 64'd0);
        ledClk = 1'b1; ledData = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("t5_reset_outputs",
                    {17'd0, pixValid, pixIdx, pixBright, pixBlue, pixGreen, pixRed,
                     frameDone, frameErr, frameCount, inFrame}, 64'd0);
        reset = 1'b0;
        expFc = 0;
        repeat (5) tick();
        sendZeros(31, 1'b0);
        sendWord(32'hF0000F00, 1'b0);
        checkOutput("t5_no_spurious_bit", {63'd0, inFrame}, 64'd0);
        sendGoodFrame(32, 1'b0);
        sendZeros(64, 1'b0);
        checkOutput("t5_frame_count", {56'd0, frameCount}, 64'd1);
        checkOutput("t5_sb_empty_end", 64'(sbQueue.size()), 64'd0);

        $display("[TB] T6 256 back-to-back frames on the 1-LED instance");
        sendZeros(8, 1'b1);
        for (int f = 0; f < 256; f++) begin
            sendWord(randWord(), 1'b1);
            sendZeros(9, 1'b1);
            sendZeros(7, 1'b1);
            if (f == 254) checkOutput("t6_count_255", {56'd0, sFrameCount}, 64'd255);
        end
        checkOutput("t6_count_wrap", {56'd0, sFrameCount}, 64'd0);
        checkOutput("t6_all_decoded", 64'(sValidCount), 64'd256);
        checkOutput("t6_no_err", 64'(sErrCount), 64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
